rsp_split: RTL and testbench
============================

RSP_SPLIT -- requirements
Module: rsp_split

Interface
REQ-001 SHALL have parameter STREAMS, default 16, number of cacheline streams; fixed at 16 in this release.
REQ-002 SHALL have parameter IDW, default 4, width of stream id; log2(STREAMS).
REQ-003 SHALL have parameter WIDTH, default 64, response payload width per stream.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port i_v, input, 1, merged response valid.
REQ-007 SHALL have port i_r, output, 1, merged response ready.
REQ-008 SHALL have port i_clid, input, IDW, destination stream id of the response.
REQ-009 SHALL have port i_d, input, WIDTH, response payload.
REQ-010 SHALL have port o_clrsp_v, output, STREAMS, per-stream response valid.
REQ-011 SHALL have port o_clrsp_r, input, STREAMS, per-stream response ready.
REQ-012 SHALL have port o_clrsp_d, output, STREAMS*WIDTH, per-stream payload; stream k at bits [k*WIDTH +: WIDTH].
REQ-013 SHALL have port o_occ, output, IDW+1, registered count of occupied slots.

Function
REQ-014 SHALL hold one slot per stream: slot_v[k] plus slot_d[k].
REQ-015 SHALL drive o_clrsp_v[k] = slot_v[k] and o_clrsp_d[k] = slot_d[k] directly from registers.
REQ-016 SHALL drive i_r = ~slot_v[i_clid] | o_clrsp_r[i_clid], combinationally, with no dependence on i_v.
REQ-017 SHALL accept a response when i_v & i_r; the payload is written to slot_d[i_clid] and slot_v[i_clid] is set on the same edge.
REQ-018 SHALL present an accepted response on o_clrsp_v[i_clid] the cycle after acceptance: latency 1, no bypass.
REQ-019 SHALL drain slot k when o_clrsp_v[k] & o_clrsp_r[k], clearing slot_v[k] on that edge unless the slot is reloaded on the same edge.
REQ-020 SHALL, when load and drain hit the same slot on one edge, keep slot_v=1 and take the new payload, giving 1 response/cycle/stream throughput.
REQ-021 SHALL drain any number of slots in one cycle, independently of the input.
REQ-022 SHALL deassert i_r when the target slot is full and its stream is not ready (head-of-line block); slots of other streams keep draining.
REQ-023 SHALL leave slot_d unchanged when no load occurs; o_clrsp_d is don't-care while o_clrsp_v[k]=0 but shall not be X after reset.
REQ-024 SHALL update o_occ each edge to the popcount of the next-state slot_v; range 0..STREAMS, where 16 needs 5 bits.
REQ-025 SHALL ignore i_clid and i_d while i_v=0, and shall not create any slot state from them.
REQ-026 SHALL allow i_v to drop without acceptance; it has no obligation to hold.

Reset
REQ-027 SHALL, on reset assertion, asynchronously clear all slot_v, slot_d and o_occ to 0 without waiting for clk.
REQ-028 SHALL drive i_r = 1 during reset and after reset; a response presented while reset=1 is discarded.
REQ-029 SHALL, on reset mid-operation, drop all pending slots without delivering them; o_clrsp_v = 16'h0000 in the next observable cycle.

Verification
REQ-030 Single route: after reset, for each clid 0..15, i_v=1, i_d=clid+100, all o_clrsp_r=1 -> o_clrsp_v = 2**clid one cycle later with payload clid+100, and o_occ goes 1 then 0.
REQ-031 Back-to-back same stream: clid=5 on 4 consecutive cycles, o_clrsp_r[5]=1 -> i_r stays 1 throughout; o_clrsp_v[5] is high for 4 cycles with payloads in order.
REQ-032 Blocking: o_clrsp_r=0, send clid=2 then clid=2 -> the first is accepted, then i_r=0 for the second; after raising o_clrsp_r[2], the second is accepted in that same cycle and delivered next.
REQ-033 Non-blocking fill: o_clrsp_r=0, send clid 0..15 on consecutive cycles -> all 16 are accepted, o_clrsp_v=16'hFFFF, o_occ=16; raising o_clrsp_r=16'hFFFF gives o_occ=0 and o_clrsp_v=0 next cycle.
REQ-034 Mixed drain: slots 1,2,5,6 full, o_clrsp_r=16'h0022 -> on the next edge o_clrsp_v=16'h0044 and o_occ=2.
REQ-035 Reset mid-operation: o_occ=16, assert reset between clock edges -> o_clrsp_v=0 and o_occ=0 immediately; after release, clid=3 is accepted and delivered normally.

Source files
------------

// File: rtl/rsp_split.sv
// Response splitter: routes one merged response stream into per-stream
// single-entry slots, one registered slot per destination stream.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   i_v/i_r         merged response handshake
//   i_clid, i_d     destination stream id and payload
//   o_clrsp_v/_r    per-stream response handshake (one bit per stream)
//   o_clrsp_d       per-stream payloads, stream k at [k*WIDTH +: WIDTH]
//   o_occ           registered count of occupied slots
module rsp_split #(
    parameter int STREAMS = 16,
    parameter int IDW     = 4,
    parameter int WIDTH   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_v,
    output logic                     i_r,
    input  logic [IDW-1:0]           i_clid,
    input  logic [WIDTH-1:0]         i_d,
    output logic [STREAMS-1:0]       o_clrsp_v,
    input  logic [STREAMS-1:0]       o_clrsp_r,
    output logic [STREAMS*WIDTH-1:0] o_clrsp_d,
    output logic [IDW:0]             o_occ
);

    logic [STREAMS-1:0] slot_v;
    logic [STREAMS-1:0] slot_v_nxt;
    logic [STREAMS-1:0] load;
    logic [STREAMS-1:0] drain;
    logic [WIDTH-1:0]   slot_d [STREAMS];
    logic [IDW:0]       occ_nxt;

    // A full slot still accepts when its stream drains on the same edge,
    // so a stream can sustain one response per cycle.
    always_comb begin
        i_r = ~slot_v[i_clid] | o_clrsp_r[i_clid];
    end

    always_comb begin
        load = '0;
        if (i_v && i_r) begin
            load[i_clid] = 1'b1;
        end
    end

    // Drain first, then load: a simultaneous load keeps the slot valid.
    always_comb begin
        drain      = slot_v & o_clrsp_r;
        slot_v_nxt = (slot_v & ~drain) | load;
    end

    always_comb begin
        occ_nxt = '0;
        for (int k = 0; k < STREAMS; k++) begin
            occ_nxt = occ_nxt + {{IDW{1'b0}}, slot_v_nxt[k]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_v <= '0;
            o_occ  <= '0;
            for (int k = 0; k < STREAMS; k++) begin
                slot_d[k] <= '0;
            end
        end else begin
            slot_v <= slot_v_nxt;
            o_occ  <= occ_nxt;
            for (int k = 0; k < STREAMS; k++) begin
                if (load[k]) begin
                    slot_d[k] <= i_d;
                end
            end
        end
    end

    assign o_clrsp_v = slot_v;

    for (genvar g = 0; g < STREAMS; g++) begin : g_out
        assign o_clrsp_d[g*WIDTH +: WIDTH] = slot_d[g];
    end

endmodule

// File: tb/tb_rsp_split.sv
// Bench for rsp_split: directed scenarios plus random traffic, checked
// against a per-stream slot model held in plain arrays.
module tb_rsp_split;

    localparam int S = 16;
    localparam int W = 64;

    logic           clk;
    logic           reset;
    logic           i_v;
    logic           i_r;
    logic [3:0]     i_clid;
    logic [W-1:0]   i_d;
    logic [S-1:0]   o_clrsp_v;
    logic [S-1:0]   o_clrsp_r;
    logic [S*W-1:0] o_clrsp_d;
    logic [4:0]     o_occ;

    int checks;
    int errors;

    bit           mv [S];
    logic [W-1:0] md [S];

    rsp_split #(.STREAMS(S), .IDW(4), .WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_v       (i_v),
        .i_r       (i_r),
        .i_clid    (i_clid),
        .i_d       (i_d),
        .o_clrsp_v (o_clrsp_v),
        .o_clrsp_r (o_clrsp_r),
        .o_clrsp_d (o_clrsp_d),
        .o_occ     (o_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [S-1:0] model_v();
        logic [S-1:0] v;
        for (int k = 0; k < S; k++) v[k] = mv[k];
        return v;
    endfunction

    function automatic int model_occ();
        int n;
        n = 0;
        for (int k = 0; k < S; k++) n += int'(mv[k]);
        return n;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < S; k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
        end
    endtask

    // One clock cycle with the inputs currently driven: check ready,
    // advance the model, then check all registered outputs.
    task automatic step(input string tag);
        bit exp_ir;
        bit acc;
        #1;
        exp_ir = !mv[i_clid] || o_clrsp_r[i_clid];
        chk({tag, "_ir"}, W'(i_r), W'(exp_ir));
        acc = i_v && exp_ir;
        for (int k = 0; k < S; k++) begin
            if (mv[k] && o_clrsp_r[k]) mv[k] = 1'b0;
        end
        if (acc) begin
            mv[i_clid] = 1'b1;
            md[i_clid] = i_d;
        end
        @(posedge clk);
        #1;
        chk({tag, "_v"}, W'(o_clrsp_v), W'(model_v()));
        chk({tag, "_occ"}, W'(o_occ), W'(model_occ()));
        for (int k = 0; k < S; k++) begin
            if (mv[k]) begin
                chk($sformatf("%s_d%0d", tag, k),
                    o_clrsp_d[k*W +: W], md[k]);
            end
        end
    endtask

    task automatic send(input int id, input logic [W-1:0] d,
                        input string tag);
        i_v    = 1'b1;
        i_clid = 4'(id);
        i_d    = d;
        step(tag);
        i_v    = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        i_v       = 1'b0;
        i_clid    = '0;
        i_d       = '0;
        o_clrsp_r = '0;
        model_clear();

        #1;
        chk("rst_v", W'(o_clrsp_v), '0);
        chk("rst_occ", W'(o_occ), '0);
        chk("rst_ir", W'(i_r), 64'd1);
        chk("rst_d_lo", o_clrsp_d[W-1:0], '0);
        chk("rst_d_hi", o_clrsp_d[S*W-1 -: W], '0);

        // Response offered during reset is discarded.
        i_v    = 1'b1;
        i_clid = 4'd9;
        i_d    = 64'hDEAD;
        @(posedge clk);
        #1;
        chk("rst_discard", W'(o_clrsp_v), '0);
        reset = 1'b0;
        i_v   = 1'b0;

        // Single route through every stream.
        o_clrsp_r = '1;
        for (int c = 0; c < S; c++) begin
            send(c, W'(c + 100), $sformatf("route%0d", c));
            chk($sformatf("route%0d_onehot", c), W'(o_clrsp_v),
                W'(1 << c));
            chk($sformatf("route%0d_pay", c), o_clrsp_d[c*W +: W],
                W'(c + 100));
            chk($sformatf("route%0d_occ1", c), W'(o_occ), 64'd1);
            step($sformatf("route%0d_drain", c));
            chk($sformatf("route%0d_occ0", c), W'(o_occ), 64'd0);
        end

        // Back-to-back on stream 5, draining every cycle.
        o_clrsp_r = 16'h0020;
        for (int n = 0; n < 4; n++) begin
            send(5, W'(500 + n), $sformatf("b2b%0d", n));
            chk($sformatf("b2b%0d_v5", n), W'(o_clrsp_v[5]), 64'd1);
            chk($sformatf("b2b%0d_pay", n), o_clrsp_d[5*W +: W],
                W'(500 + n));
        end
        step("b2b_tail");

        // Head-of-line block on stream 2.
        o_clrsp_r = '0;
        send(2, 64'hA1, "blk_first");
        i_v    = 1'b1;
        i_clid = 4'd2;
        i_d    = 64'hA2;
        #1;
        chk("blk_ir_low", W'(i_r), 64'd0);
        step("blk_held");
        o_clrsp_r[2] = 1'b1;
        #1;
        chk("blk_ir_high", W'(i_r), 64'd1);
        step("blk_accept");
        i_v = 1'b0;
        chk("blk_second", o_clrsp_d[2*W +: W], 64'hA2);
        step("blk_tail");

        // Fill all 16 slots with no downstream ready.
        o_clrsp_r = '0;
        for (int c = 0; c < S; c++) begin
            send(c, W'({$urandom, $urandom}), $sformatf("fill%0d", c));
        end
        chk("fill_v", W'(o_clrsp_v), 64'hFFFF);
        chk("fill_occ", W'(o_occ), 64'd16);
        o_clrsp_r = '1;
        step("fill_drain");
        chk("fill_empty_v", W'(o_clrsp_v), '0);
        chk("fill_empty_occ", W'(o_occ), '0);

        // Mixed drain of a partially full set.
        o_clrsp_r = '0;
        send(1, 64'h11, "mix1");
        send(2, 64'h22, "mix2");
        send(5, 64'h55, "mix5");
        send(6, 64'h66, "mix6");
        o_clrsp_r = 16'h0022;
        step("mix_drain");
        chk("mix_v", W'(o_clrsp_v), 64'h0044);
        chk("mix_occ", W'(o_occ), 64'd2);
        o_clrsp_r = '1;
        step("mix_tail");

        // Reset between clock edges with all slots full.
        o_clrsp_r = '0;
        for (int c = 0; c < S; c++) begin
            send(c, W'(c * 7 + 3), $sformatf("pre%0d", c));
        end
        chk("pre_occ", W'(o_occ), 64'd16);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        chk("mid_rst_v", W'(o_clrsp_v), '0);
        chk("mid_rst_occ", W'(o_occ), '0);
        chk("mid_rst_ir", W'(i_r), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        o_clrsp_r = '1;
        send(3, 64'h333, "post_rst");
        chk("post_rst_v", W'(o_clrsp_v), 64'h0008);
        step("post_rst_drain");

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            i_v       = 1'($urandom_range(0, 3) != 0);
            i_clid    = 4'($urandom);
            i_d       = {$urandom, $urandom};
            o_clrsp_r = 16'($urandom) & 16'($urandom);
            step($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
